// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-bit adder slice reused over WIDTH/CHUNK cycles,
// with the inter-chunk carry held in a register and a start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             accept, run, last;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run    = (state_q == RUN);
    accept = (state_q == IDLE) && start;
    busy   = run;
  end

  assign last = (count_q == CW'(N - 1));

  // Chunk slice selected by the counter; carry into the MSB is recovered from the sum bit.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (count_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    msb_cin   = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    count_d = count_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept) begin
      // Subtraction is a + ~b + 1, so the carry register doubles as the +1.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      count_d = '0;
    end else if (run) begin
      for (int i = 0; i < N; i++) begin
        if (count_q == CW'(i)) res_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
      carry_d = chunk_sum[CHUNK];
      count_d = count_q + CW'(1);
      if (last) begin
        sum_d  = res_d;
        cout_d = chunk_sum[CHUNK];
        ovf_d  = msb_cin ^ chunk_sum[CHUNK];
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      count_q <= count_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: a 32/8 instance and a degenerate 8/8 instance.
module tb_seq_chunk_adder;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          dc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;
  logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t hold[2];

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic clear_hold();
    for (int i = 0; i < 2; i++) begin
      hold[i].s  = '0;
      hold[i].co = 1'b0;
      hold[i].ov = 1'b0;
      hold[i].dc = 0;
    end
  endtask

  task automatic mon(input int id, input int n, input logic dn, input logic bsy,
                     input logic [31:0] s, input logic co, input logic ov);
    exp_t e;
    logic bexp;
    int   qs;
    qs   = (id == 0) ? q32.size() : q8.size();
    bexp = 1'b0;
    if (qs > 0) begin
      e    = (id == 0) ? q32[0] : q8[0];
      bexp = (cyc >= e.dc - n) && (cyc < e.dc);
    end
    chk($sformatf("dut%0d busy", id), {31'b0, bsy}, {31'b0, bexp});
    if (dn) begin
      if (qs == 0) begin
        total++;
        bad++;
        $display("FAIL dut%0d unexpected done at cycle %0d: sum=%h, expected no done", id, cyc, s);
      end else begin
        if (id == 0) e = q32.pop_front();
        else         e = q8.pop_front();
        chk($sformatf("dut%0d done_cycle", id), cyc, e.dc);
        chk($sformatf("dut%0d sum", id), s, e.s);
        chk($sformatf("dut%0d cout", id), {31'b0, co}, {31'b0, e.co});
        chk($sformatf("dut%0d overflow", id), {31'b0, ov}, {31'b0, e.ov});
        hold[id] = e;
        $display("txn dut%0d cycle=%0d sum=%h cout=%b ovf=%b (exp %h %b %b)",
                 id, cyc, s, co, ov, e.s, e.co, e.ov);
      end
    end else begin
      chk($sformatf("dut%0d sum_hold", id), s, hold[id].s);
      chk($sformatf("dut%0d cout_hold", id), {31'b0, co}, {31'b0, hold[id].co});
      chk($sformatf("dut%0d ovf_hold", id), {31'b0, ov}, {31'b0, hold[id].ov});
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, done32, busy32, sum32, cout32, ovf32);
    mon(1, 1, done8, busy8, {24'b0, sum8}, cout8, ovf8);
  end

  // Called 2 time units after a rising edge; start is accepted on the next edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic [31:0] es,
                       input logic eco, input logic eov, input bit push);
    exp_t e;
    e.s  = es;
    e.co = eco;
    e.ov = eov;
    e.dc = cyc + 1 + ((id == 0) ? 4 : 1);
    if (push) begin
      if (id == 0) q32.push_back(e);
      else         q8.push_back(e);
    end
    if (id == 0) begin
      a32 = a; b32 = b; cin32 = ci; sub32 = sb; start32 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; sub8 = sb; start8 = 1'b1;
    end
    @(posedge clk);
    #2;
    // Scramble operands after accept; the latched copy must be used.
    if (id == 0) begin
      start32 = 1'b0; a32 = ~a; b32 = a ^ b; cin32 = ~ci; sub32 = ~sb;
    end else begin
      start8 = 1'b0; a8 = ~a[7:0]; b8 = a[7:0] ^ b[7:0]; cin8 = ~ci; sub8 = ~sb;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  vec_t vecs[8];

  initial begin
    clear_hold();
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vecs[4] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h00000009, 32'h00000009, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};

    cycles(3);
    reset = 1'b0;
    cycles(10);

    foreach (vecs[i]) begin
      issue(0, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b1);
      cycles(5);
    end

    // Start pulsed two cycles into an operation must be ignored.
    issue(0, 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b1);
    cycles(1);
    issue(0, 32'h00001000, 32'h00002000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycles(6);

    // Back-to-back: second start lands in the done cycle of the first.
    issue(0, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b1);
    cycles(4);
    issue(0, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    cycles(6);

    // Reset two cycles after start aborts the operation with no done.
    issue(0, 32'h12345678, 32'h00000001, 1'b0, 1'b0, 32'h12345679, 1'b0, 1'b0, 1'b1);
    cycles(1);
    reset = 1'b1;
    q32.delete();
    q8.delete();
    clear_hold();
    #1;
    chk("reset_mid sum", sum32, 32'h0);
    chk("reset_mid busy", {31'b0, busy32}, 32'h0);
    chk("reset_mid done", {31'b0, done32}, 32'h0);
    cycles(1);
    reset = 1'b0;
    cycles(6);
    issue(0, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1);
    cycles(6);

    // Degenerate single-chunk instance.
    issue(1, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
    cycles(3);
    issue(1, 32'h7F, 32'h01, 1'b0, 1'b1, 32'h7E, 1'b1, 1'b0, 1'b1);
    cycles(3);
    issue(1, 32'h40, 32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b1);
    cycles(1);
    issue(1, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
    cycles(3);

    for (int i = 0; i < 20 && (q32.size() > 0 || q8.size() > 0); i++) cycles(1);
    total++;
    if (q32.size() > 0 || q8.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending results, expected 0/0", q32.size(), q8.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
